pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
- Parametrised successor to the PC-source selection path of the multicycle CPU.
- Selects the next PC from N flattened sources and owns the PC register.
- Handles unconditional writes and conditional branch writes with beq/bne polarity.
- Runs a small exception-entry FSM: captures EPC, issues the handler-vector memory read, waits a programmable latency, then loads PC from the read byte.

Parameters:
- DATA_W, 32: width of PC and all sources.
- N_SRC, 5: number of PC sources (≥2).
- SEL_W, $clog2(N_SRC): width of pc_sel.
- MEM_LAT, 2: cycles from vec_addr valid to vec_byte valid (≥1).
- RESET_PC, 0: PC value after reset.
- VEC_BASE, 253: address of first exception vector byte.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- src_bus  in  N_SRC*DATA_W  flattened sources; source k at bits [k*DATA_W +: DATA_W].
- pc_sel  in  SEL_W  source index.
- pc_write  in  1  unconditional PC load.
- pc_write_cond  in  1  conditional PC load.
- br_ne  in  1  0 = branch on zero (beq), 1 = branch on not zero (bne).
- zero  in  1  ALU zero flag.
- exc_req  in  1  exception request pulse.
- exc_code  in  2  cause index, 0..2.
- vec_byte  in  8  memory data for the vector read.
- pc  out  DATA_W  current PC.
- epc  out  DATA_W  exception PC.
- vec_addr  out  DATA_W  vector address to memory mux.
- vec_rd  out  1  vector read active.
- busy  out  1  exception sequence in progress.
- sel_err  out  1  sticky out-of-range pc_sel flag.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, epc=0, vec_addr=0, vec_rd=0, busy=0, sel_err=0, FSM=RUN, wait counter=0.
- Selection is combinational: next = src_bus slice[pc_sel].
- pc_sel ≥ N_SRC: the load is suppressed, PC holds, and sel_err is set. sel_err stays set until reset.
- FSM RUN:
  - PC loads next on pc_write, or on pc_write_cond && (zero ^ br_ne). Load is visible the cycle after the edge.
  - pc_write and pc_write_cond both high: pc_write wins.
  - exc_req=1 has priority over any PC load in the same cycle:
    - epc <= pc (current value, pre-update).
    - vec_addr <= VEC_BASE + exc_code.
    - vec_rd <= 1, busy <= 1, counter <= MEM_LAT-1.
    - FSM -> WAIT.
  - exc_code=3 is treated as 2.
- FSM WAIT:
  - PC, epc and vec_addr hold; pc_write, pc_write_cond and exc_req are ignored.
  - Counter decrements each cycle; at 0, FSM -> LOAD.
- FSM LOAD (one cycle):
  - pc <= zero-extended vec_byte; vec_rd <= 0, busy <= 0; FSM -> RUN.
  - The new PC is visible the next cycle.
- Exception entry to first normal PC load: MEM_LAT+2 cycles.
- Reset asserted mid-sequence aborts immediately to reset values; no partial EPC retention.
- No wrap-around handling is needed beyond DATA_W truncation of the source values.

Decomposition:
- Shared package cpu_pkg holds:
  - FSM state encoding: RUN=2'd0, WAIT=2'd1, LOAD=2'd2.
  - VEC_BASE default.
  - Exception code constants: EXC_OPCODE=0, EXC_OVF=1, EXC_DIV0=2.
- One sub-module, pc_src_mux:
  - Parametrised N-to-1 combinational mux over the flattened bus.
  - Outputs the selected word and a range-valid flag.
  - Reusable by other source-select paths.
- The FSM and registers stay in pc_next_unit.

Test Plan:
- Reset, then pc_sel=1, src1=0x0000_0040, pc_write=1 for one cycle -> pc=0x40 the next cycle; sel_err=0.
- Branch polarity, src0=0x100:
  - pc_write_cond=1, zero=1, br_ne=0 -> pc=0x100.
  - Repeat with zero=1, br_ne=1 -> pc holds.
  - zero=0, br_ne=1 -> pc=0x100.
- pc_sel=6 with N_SRC=5 and pc_write=1 -> pc unchanged; sel_err=1 and stays set until reset.
- pc=0x20, exc_req=1, exc_code=1, pc_write=1 in the same cycle:
  - Next cycle: epc=0x20, vec_addr=254, busy=1, pc=0x20.
  - vec_byte=0x8C at latency 2 -> pc=0x0000_008C at cycle 4; busy=0.
- During WAIT, pulse pc_write and exc_req -> no change to pc, epc or vec_addr.
- Assert reset in WAIT -> pc=RESET_PC, busy=0, vec_rd=0, epc=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the PC-source / exception-entry path.
//   - pc_state_e : exception-entry FSM encoding (RUN / WAIT / LOAD)
//   - VEC_BASE_DEF : default address of the first exception vector byte
//   - EXC_*       : exception cause codes
//   - clamp_exc_code() : folds the unused cause code 3 onto EXC_DIV0
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } pc_state_e;

  localparam int VEC_BASE_DEF = 253;

  localparam logic [1:0] EXC_OPCODE = 2'd0;
  localparam logic [1:0] EXC_OVF    = 2'd1;
  localparam logic [1:0] EXC_DIV0   = 2'd2;

  // Cause code 3 has no vector of its own; it shares the DIV0 entry.
  function automatic logic [1:0] clamp_exc_code(input logic [1:0] code);
    logic [1:0] res;
    if (code == 2'd3) begin
      res = EXC_DIV0;
    end else begin
      res = code;
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_src_mux.sv
// pc_src_mux: parametrised N-to-1 combinational word mux over a flattened bus.
// Ports:
//   i_bus   [N_SRC*DATA_W] flattened sources, source k at [k*DATA_W +: DATA_W]
//   i_sel   [SEL_W]        source index
//   o_word  [DATA_W]       selected word (zero when i_sel is out of range)
//   o_valid                1 when i_sel < N_SRC
module pc_src_mux #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 5,
  parameter int SEL_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC*DATA_W-1:0] i_bus,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [DATA_W-1:0]       o_word,
  output logic                    o_valid
);

  // AND-OR select: each source contributes only when its index matches, so an
  // out-of-range index yields zero and leaves o_valid low.
  always_comb begin
    o_word  = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      o_word  = o_word | (i_bus[k*DATA_W +: DATA_W] & {DATA_W{i_sel == SEL_W'(k)}});
      o_valid = o_valid | (i_sel == SEL_W'(k));
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC selection, PC register and exception-entry sequencer.
// Ports:
//   clk, reset (async, active-low)
//   src_bus [N_SRC*DATA_W]  flattened PC sources
//   pc_sel  [SEL_W]         source index
//   pc_write / pc_write_cond / br_ne / zero : PC load controls
//   exc_req, exc_code[2]    exception request and cause
//   vec_byte [8]            memory data for the handler-vector read
//   pc, epc, vec_addr [DATA_W]; vec_rd, busy, sel_err : registered outputs
// Exception entry: RUN --exc_req--> WAIT (MEM_LAT cycles) --> LOAD --> RUN.
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              N_SRC    = 5,
  parameter int              SEL_W    = $clog2(N_SRC),
  parameter int              MEM_LAT  = 2,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int              VEC_BASE = VEC_BASE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC*DATA_W-1:0] src_bus,
  input  logic [SEL_W-1:0]        pc_sel,
  input  logic                    pc_write,
  input  logic                    pc_write_cond,
  input  logic                    br_ne,
  input  logic                    zero,
  input  logic                    exc_req,
  input  logic [1:0]              exc_code,
  input  logic [7:0]              vec_byte,
  output logic [DATA_W-1:0]       pc,
  output logic [DATA_W-1:0]       epc,
  output logic [DATA_W-1:0]       vec_addr,
  output logic                    vec_rd,
  output logic                    busy,
  output logic                    sel_err
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  pc_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_epc;
  logic [DATA_W-1:0] r_vec_addr;
  logic              r_vec_rd;
  logic              r_busy;
  logic              r_sel_err;

  pc_state_e         w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] w_epc_nxt;
  logic [DATA_W-1:0] w_vec_addr_nxt;
  logic              w_vec_rd_nxt;
  logic              w_busy_nxt;
  logic              w_sel_err_nxt;

  logic [DATA_W-1:0] w_sel_word;
  logic              w_sel_valid;
  logic              w_load_req;

  pc_src_mux #(
    .DATA_W (DATA_W),
    .N_SRC  (N_SRC),
    .SEL_W  (SEL_W)
  ) u_src_mux (
    .i_bus   (src_bus),
    .i_sel   (pc_sel),
    .o_word  (w_sel_word),
    .o_valid (w_sel_valid)
  );

  // A conditional write is taken when zero disagrees with the bne polarity bit.
  assign w_load_req = pc_write | (pc_write_cond & (zero ^ br_ne));

  // Next-state and next-register computation for the exception-entry FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_nxt       = r_pc;
    w_epc_nxt      = r_epc;
    w_vec_addr_nxt = r_vec_addr;
    w_vec_rd_nxt   = r_vec_rd;
    w_busy_nxt     = r_busy;
    w_sel_err_nxt  = r_sel_err;
    case (r_state)
      ST_RUN: begin
        if (exc_req) begin
          // Exception wins over any PC load; EPC captures the pre-update PC.
          w_epc_nxt      = r_pc;
          w_vec_addr_nxt = DATA_W'(VEC_BASE) + DATA_W'(clamp_exc_code(exc_code));
          w_vec_rd_nxt   = 1'b1;
          w_busy_nxt     = 1'b1;
          w_cnt_nxt      = CNT_W'(MEM_LAT - 1);
          w_state_nxt    = ST_WAIT;
        end else if (w_load_req) begin
          if (w_sel_valid) begin
            w_pc_nxt = w_sel_word;
          end else begin
            w_sel_err_nxt = 1'b1;
          end
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      ST_WAIT: begin
        // Load requests and new exceptions are ignored while the read is in flight.
        if (r_cnt == '0) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        w_pc_nxt     = DATA_W'(vec_byte);
        w_vec_rd_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = ST_RUN;
      end
      default: begin
        // Unreachable encoding: drop any sequence in progress and resume.
        w_vec_rd_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_cnt_nxt    = '0;
        w_state_nxt  = ST_RUN;
      end
    endcase
  end

  // State and datapath registers; reset aborts any sequence immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_pc       <= RESET_PC;
      r_epc      <= '0;
      r_vec_addr <= '0;
      r_vec_rd   <= 1'b0;
      r_busy     <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_epc      <= w_epc_nxt;
      r_vec_addr <= w_vec_addr_nxt;
      r_vec_rd   <= w_vec_rd_nxt;
      r_busy     <= w_busy_nxt;
      r_sel_err  <= w_sel_err_nxt;
    end
  end

  assign pc       = r_pc;
  assign epc      = r_epc;
  assign vec_addr = r_vec_addr;
  assign vec_rd   = r_vec_rd;
  assign busy     = r_busy;
  assign sel_err  = r_sel_err;

endmodule
